// File: rtl/prog_loader.sv
// Boot-time program loader: streams host bytes into the 16-word CPU RAM over the
// shared bus (MAR load, then RAM write), then resets the CPU and releases the bus.
module prog_loader #(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] bus_o,
  output logic              bus_oe,
  output logic              mi_o,
  output logic              ri_o,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_ADDR,
    S_DATA,
    S_RELEASE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(WORDS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                aborted_q, aborted_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                abort_pend_q, abort_pend_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      aborted_q    <= 1'b0;
      data_q       <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      aborted_q    <= aborted_d;
      data_q       <= data_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    aborted_d    = aborted_q;
    data_d       = data_q;
    abort_pend_d = abort_pend_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_WAIT_DATA;
          addr_d       = '0;
          count_d      = '0;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
        end
      end
      S_WAIT_DATA: begin
        // abort has priority: a byte offered in the same cycle is refused
        if (abort) begin
          state_d   = S_RELEASE;
          aborted_d = 1'b1;
        end else if (wr_valid) begin
          data_d  = wr_data;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        // an abort here only takes effect after the word's data phase
        abort_pend_d = abort;
        state_d      = S_DATA;
      end
      S_DATA: begin
        count_d = (count_q == MAX_COUNT) ? count_q : count_q + 1'b1;
        if (addr_q == LAST_ADDR || abort_pend_q || abort) begin
          state_d   = S_RELEASE;
          aborted_d = abort_pend_q | abort;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_WAIT_DATA;
        end
      end
      S_RELEASE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_o = '0;
    if (state_q == S_ADDR)      bus_o = DATA_W'(addr_q);
    else if (state_q == S_DATA) bus_o = data_q;
  end

  assign wr_ready = (state_q == S_WAIT_DATA) && !abort;
  assign bus_oe   = (state_q == S_ADDR) || (state_q == S_DATA);
  assign mi_o     = (state_q == S_ADDR);
  assign ri_o     = (state_q == S_DATA);
  assign cpu_hold = (state_q == S_WAIT_DATA) || (state_q == S_ADDR) ||
                    (state_q == S_DATA) || (state_q == S_RELEASE);
  assign cpu_rst  = (state_q == S_RELEASE);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign aborted  = aborted_q;
  assign count    = count_q;

endmodule
